// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//  Shared types and constants for the writeback stage:
//   - wb_sel_e      : writeback source select (ALU / load / PC+4 / immediate)
//   - F3_*          : load funct3 encodings (size and signedness)
//   - XLEN_DEF/CNT_W_DEF : default datapath and retired-counter widths
//   - sext8/sext16  : sign-extension helpers for load alignment
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 64;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_IMM  = 2'b11
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// ----------------------------------------------------------------------------
// wb_stage_if
//  Bundles the MEM->WB capture inputs and the register-file / status outputs
//  of the writeback stage.
//   master : upstream / environment side (drives i_*, observes o_*)
//   slave  : wb_stage side (observes i_*, drives o_*)
//  Signal names keep the stage's port naming so they line up with the
//  register file and MEM stage.
// ----------------------------------------------------------------------------
interface wb_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   logic             i_stall;
   logic             i_flush;
   logic             i_mem_valid;
   logic [XLEN-1:0]  i_mem_pc;
   logic [4:0]       i_mem_rd_addr;
   logic             i_mem_rd_wren;
   logic [1:0]       i_mem_wb_sel;
   logic [XLEN-1:0]  i_mem_alu_data;
   logic [XLEN-1:0]  i_mem_imm;
   logic [XLEN-1:0]  i_mem_ld_data;
   logic [2:0]       i_mem_funct3;

   logic [4:0]       o_rd_addr;
   logic [XLEN-1:0]  o_rd_data;
   logic             o_rd_wren;
   logic             o_wb_valid;
   logic [XLEN-1:0]  o_wb_pc;
   logic             o_ld_misalign;
   logic [CNT_W-1:0] o_instret;

   modport master (
      output i_stall, i_flush, i_mem_valid, i_mem_pc, i_mem_rd_addr,
             i_mem_rd_wren, i_mem_wb_sel, i_mem_alu_data, i_mem_imm,
             i_mem_ld_data, i_mem_funct3,
      input  o_rd_addr, o_rd_data, o_rd_wren, o_wb_valid, o_wb_pc,
             o_ld_misalign, o_instret
   );

   modport slave (
      input  i_stall, i_flush, i_mem_valid, i_mem_pc, i_mem_rd_addr,
             i_mem_rd_wren, i_mem_wb_sel, i_mem_alu_data, i_mem_imm,
             i_mem_ld_data, i_mem_funct3,
      output o_rd_addr, o_rd_data, o_rd_wren, o_wb_valid, o_wb_pc,
             o_ld_misalign, o_instret
   );
endinterface

// File: rtl/wb_stage_load_align.sv
// ----------------------------------------------------------------------------
// load_align
//  Combinational load-data alignment for a 32-bit word-aligned memory.
//  Ports:
//   ld_data  in  32  raw word read from data memory
//   off      in  2   byte offset (low address bits)
//   funct3   in  3   load size / signedness
//   data     out 32  aligned, sign/zero-extended load value (0 for
//                    non-load encodings)
//   misalign out 1   access crosses its natural alignment
// ----------------------------------------------------------------------------
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] ld_data,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        misalign
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection: byte lane picked by full offset, half lane by off[1].
   always_comb begin
      byte_s = ld_data[{off, 3'b000} +: 8];
      if (off[1]) begin
         half_s = ld_data[31:16];
      end else begin
         half_s = ld_data[15:0];
      end
   end

   // Extension and alignment check per load type.
   always_comb begin
      data     = 32'd0;
      misalign = 1'b0;
      case (funct3)
         F3_LB:  begin data = sext8(byte_s);          misalign = 1'b0;          end
         F3_LBU: begin data = {24'd0, byte_s};        misalign = 1'b0;          end
         F3_LH:  begin data = sext16(half_s);         misalign = off[0];        end
         F3_LHU: begin data = {16'd0, half_s};        misalign = off[0];        end
         F3_LW:  begin data = ld_data;                misalign = (off != 2'd0); end
         default: begin data = 32'd0;                 misalign = 1'b0;          end
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
//  MEM/WB pipeline register plus writeback value selection. Feeds the
//  register file write port and keeps a retired-instruction counter.
//  Ports:
//   i_clk  in  1   clock, all state on posedge
//   i_rst  in  1   synchronous active-high reset
//   bus    slave   MEM capture inputs (stall/flush/mem_*) and outputs
//                  o_rd_addr/o_rd_data/o_rd_wren, o_wb_valid, o_wb_pc,
//                  o_ld_misalign, o_instret
//  The register-file outputs are combinational from the registered entry so
//  the regfile bypass can serve a same-cycle read.
// ----------------------------------------------------------------------------
module wb_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic        i_clk,
   input logic        i_rst,
   wb_stage_if.slave  bus
);

   logic              valid_r;
   logic [XLEN-1:0]   pc_r;
   logic [4:0]        rd_addr_r;
   logic              rd_wren_r;
   wb_sel_e           wb_sel_r;
   logic [XLEN-1:0]   alu_r;
   logic [XLEN-1:0]   imm_r;
   logic [XLEN-1:0]   ld_r;
   logic [2:0]        funct3_r;
   logic              retired_r;
   logic [CNT_W-1:0]  instret_r;

   logic [31:0]       la_data_s;
   logic              la_misalign_s;
   logic              misalign_s;
   logic              retire_s;
   logic [XLEN-1:0]   wb_data_s;

   // An entry counts once: on the first edge it sits valid in WB.
   assign retire_s = valid_r & ~retired_r;

   // MEM/WB capture with reset > flush > stall > load priority, plus instret.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_r   <= 1'b0;
         pc_r      <= '0;
         rd_addr_r <= 5'd0;
         rd_wren_r <= 1'b0;
         wb_sel_r  <= WB_ALU;
         alu_r     <= '0;
         imm_r     <= '0;
         ld_r      <= '0;
         funct3_r  <= 3'd0;
         retired_r <= 1'b0;
         instret_r <= '0;
      end else begin
         if (bus.i_flush) begin
            // Bubble: payload fields are left as-is, only valid matters.
            valid_r   <= 1'b0;
            retired_r <= 1'b0;
         end else if (bus.i_stall) begin
            // Held entry: remember that it has already been counted.
            retired_r <= retired_r | valid_r;
         end else begin
            valid_r   <= bus.i_mem_valid;
            pc_r      <= bus.i_mem_pc;
            rd_addr_r <= bus.i_mem_rd_addr;
            rd_wren_r <= bus.i_mem_rd_wren;
            wb_sel_r  <= wb_sel_e'(bus.i_mem_wb_sel);
            alu_r     <= bus.i_mem_alu_data;
            imm_r     <= bus.i_mem_imm;
            ld_r      <= bus.i_mem_ld_data;
            funct3_r  <= bus.i_mem_funct3;
            retired_r <= 1'b0;
         end
         instret_r <= instret_r + {{(CNT_W-1){1'b0}}, retire_s};
      end
   end

   load_align u_load_align (
      .ld_data  (ld_r[31:0]),
      .off      (alu_r[1:0]),
      .funct3   (funct3_r),
      .data     (la_data_s),
      .misalign (la_misalign_s)
   );

   // Writeback source select; PC+4 wraps naturally at the datapath width.
   always_comb begin
      wb_data_s = '0;
      case (wb_sel_r)
         WB_ALU:  wb_data_s = alu_r;
         WB_LOAD: wb_data_s = XLEN'(la_data_s);
         WB_PC4:  wb_data_s = pc_r + XLEN'(4);
         WB_IMM:  wb_data_s = imm_r;
         default: wb_data_s = '0;
      endcase
   end

   // Misalignment only means something for loads in a valid entry.
   always_comb begin
      if (valid_r && (wb_sel_r == WB_LOAD)) begin
         misalign_s = la_misalign_s;
      end else begin
         misalign_s = 1'b0;
      end
   end

   assign bus.o_rd_addr     = rd_addr_r;
   assign bus.o_rd_data     = wb_data_s;
   // x0 is hardwired zero; a stalled entry simply rewrites the same value.
   assign bus.o_rd_wren     = valid_r & rd_wren_r & (rd_addr_r != 5'd0) & ~misalign_s;
   assign bus.o_wb_valid    = valid_r;
   assign bus.o_wb_pc       = pc_r;
   assign bus.o_ld_misalign = misalign_s;
   assign bus.o_instret     = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();

   wb_stage #(.XLEN(32), .CNT_W(64)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        valid;
      logic        flush;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wren;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] imm;
      logic [31:0] ld;
      logic [2:0]  f3;
      logic        e_valid;
      logic        e_wren;
      logic        e_mis;
      logic        chk_data;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic valid, input logic flush, input logic [31:0] pc,
                      input logic [4:0] rd, input logic wren, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] imm, input logic [2:0] f3,
                      input logic e_valid, input logic e_wren, input logic e_mis,
                      input logic chk_data, input logic [31:0] e_data);
      vec_t v;
      v.valid = valid; v.flush = flush; v.pc = pc; v.rd = rd; v.wren = wren;
      v.sel = sel; v.alu = alu; v.imm = imm; v.ld = 32'h80FF7F01; v.f3 = f3;
      v.e_valid = e_valid; v.e_wren = e_wren; v.e_mis = e_mis;
      v.chk_data = chk_data; v.e_data = e_data;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic [31:0] pc, input logic [4:0] rd,
                        input logic wren, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] imm, input logic [31:0] ld, input logic [2:0] f3);
      bus.i_mem_valid    = valid;
      bus.i_mem_pc       = pc;
      bus.i_mem_rd_addr  = rd;
      bus.i_mem_rd_wren  = wren;
      bus.i_mem_wb_sel   = sel;
      bus.i_mem_alu_data = alu;
      bus.i_mem_imm      = imm;
      bus.i_mem_ld_data  = ld;
      bus.i_mem_funct3   = f3;
   endtask

   longint exp_cnt;
   logic   prev_live;

   initial begin
      bus.i_stall = 1'b0;
      bus.i_flush = 1'b0;
      // Garbage valid entry during reset must be ignored.
      drive(1'b1, 32'h0000_1234, 5'd3, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'd0);

      // ---------------- reset ----------------
      rst = 1'b1;
      step();
      step();
      chk("rst_wb_valid", {63'd0, bus.o_wb_valid}, 64'd0);
      chk("rst_rd_wren",  {63'd0, bus.o_rd_wren}, 64'd0);
      chk("rst_rd_data",  {32'd0, bus.o_rd_data}, 64'd0);
      chk("rst_rd_addr",  {59'd0, bus.o_rd_addr}, 64'd0);
      chk("rst_wb_pc",    {32'd0, bus.o_wb_pc}, 64'd0);
      chk("rst_misalign", {63'd0, bus.o_ld_misalign}, 64'd0);
      chk("rst_instret",  bus.o_instret, 64'd0);
      rst = 1'b0;

      // -------- table: valid flush pc rd wren sel alu imm f3 | e_valid e_wren e_mis chk e_data
      add(1,0,32'h1000,5'd5,1,2'b00,32'h12345678,32'h0,3'd0, 1,1,0,1,32'h12345678); // ALU
      add(1,0,32'h1004,5'd6,1,2'b01,32'h00001003,32'h0,3'd0, 1,1,0,1,32'hFFFFFF80); // LB off3
      add(1,0,32'h1008,5'd6,1,2'b01,32'h00002001,32'h0,3'd4, 1,1,0,1,32'h0000007F); // LBU off1
      add(1,0,32'h100C,5'd6,1,2'b01,32'h00002002,32'h0,3'd1, 1,1,0,1,32'hFFFF80FF); // LH off2
      add(1,0,32'h1010,5'd6,1,2'b01,32'h00002000,32'h0,3'd5, 1,1,0,1,32'h00007F01); // LHU off0
      add(1,0,32'h1014,5'd6,1,2'b01,32'h00002000,32'h0,3'd2, 1,1,0,1,32'h80FF7F01); // LW off0
      add(1,0,32'h1018,5'd7,1,2'b01,32'h00002002,32'h0,3'd2, 1,0,1,0,32'h0);        // LW off2 misalign
      add(1,0,32'h101C,5'd7,1,2'b01,32'h00002003,32'h0,3'd5, 1,0,1,0,32'h0);        // LHU off3 misalign
      add(1,0,32'h1020,5'd8,1,2'b01,32'h00002002,32'h0,3'd0, 1,1,0,1,32'hFFFFFFFF); // LB off2
      add(1,0,32'h1024,5'd8,1,2'b01,32'h00002000,32'h0,3'd0, 1,1,0,1,32'h00000001); // LB off0
      add(1,0,32'h1028,5'd8,1,2'b01,32'h00002000,32'h0,3'd3, 1,1,0,1,32'h00000000); // f3=011
      add(1,0,32'h102C,5'd8,1,2'b01,32'h00002000,32'h0,3'd7, 1,1,0,1,32'h00000000); // f3=111
      add(1,0,32'hFFFFFFFC,5'd1,1,2'b10,32'h0,32'h0,3'd0,    1,1,0,1,32'h00000000); // PC+4 wrap
      add(1,0,32'h00000100,5'd1,1,2'b10,32'h0,32'h0,3'd0,    1,1,0,1,32'h00000104); // PC+4
      add(1,0,32'h1030,5'd2,1,2'b11,32'h00000002,32'hABCDE000,3'd2, 1,1,0,1,32'hABCDE000); // IMM
      add(1,0,32'h1034,5'd2,1,2'b00,32'h00000006,32'h0,3'd2, 1,1,0,1,32'h00000006); // ALU, no misalign
      add(1,0,32'h1038,5'd0,1,2'b00,32'h00000077,32'h0,3'd0, 1,0,0,1,32'h00000077); // rd=x0
      add(0,0,32'h103C,5'd5,1,2'b01,32'h00002001,32'h0,3'd2, 0,0,0,0,32'h0);        // bubble
      add(1,0,32'h1040,5'd5,0,2'b00,32'h00000099,32'h0,3'd0, 1,0,0,1,32'h00000099); // no rd write
      add(1,1,32'h1044,5'd5,1,2'b01,32'h00002001,32'h0,3'd2, 0,0,0,0,32'h0);        // flush

      exp_cnt   = 0;
      prev_live = 1'b0;
      foreach (tbl[i]) begin
         bus.i_flush = tbl[i].flush;
         drive(tbl[i].valid, tbl[i].pc, tbl[i].rd, tbl[i].wren, tbl[i].sel,
               tbl[i].alu, tbl[i].imm, tbl[i].ld, tbl[i].f3);
         if (prev_live) exp_cnt++;
         step();
         prev_live = tbl[i].valid & ~tbl[i].flush;
         chk($sformatf("v%0d_wb_valid", i), {63'd0, bus.o_wb_valid}, {63'd0, tbl[i].e_valid});
         chk($sformatf("v%0d_rd_wren", i),  {63'd0, bus.o_rd_wren},  {63'd0, tbl[i].e_wren});
         chk($sformatf("v%0d_misalign", i), {63'd0, bus.o_ld_misalign}, {63'd0, tbl[i].e_mis});
         chk($sformatf("v%0d_instret", i),  bus.o_instret, exp_cnt);
         if (tbl[i].chk_data) begin
            chk($sformatf("v%0d_rd_data", i), {32'd0, bus.o_rd_data}, {32'd0, tbl[i].e_data});
         end
         if (tbl[i].e_valid) begin
            chk($sformatf("v%0d_rd_addr", i), {59'd0, bus.o_rd_addr}, {59'd0, tbl[i].rd});
            chk($sformatf("v%0d_wb_pc", i),   {32'd0, bus.o_wb_pc},   {32'd0, tbl[i].pc});
         end
      end
      bus.i_flush = 1'b0;

      // ---------------- stall: one entry held for 4 extra cycles ----------------
      drive(1'b1, 32'h3000, 5'd9, 1'b1, 2'b00, 32'h00000055, 32'd0, 32'd0, 3'd0);
      step();
      chk("stall_load_wren", {63'd0, bus.o_rd_wren}, 64'd1);
      chk("stall_load_cnt",  bus.o_instret, exp_cnt);
      bus.i_stall = 1'b1;
      drive(1'b1, 32'h4000, 5'd3, 1'b1, 2'b00, 32'h0000DEAD, 32'd0, 32'd0, 3'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("stall%0d_wren", k), {63'd0, bus.o_rd_wren}, 64'd1);
         chk($sformatf("stall%0d_data", k), {32'd0, bus.o_rd_data}, 64'h55);
         chk($sformatf("stall%0d_addr", k), {59'd0, bus.o_rd_addr}, 64'd9);
         chk($sformatf("stall%0d_cnt", k),  bus.o_instret, exp_cnt + 1);
      end
      bus.i_stall = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 3'd0);
      step();
      exp_cnt++;
      chk("stall_end_valid", {63'd0, bus.o_wb_valid}, 64'd0);
      chk("stall_end_cnt",   bus.o_instret, exp_cnt);
      step();
      chk("bubble_no_count", bus.o_instret, exp_cnt);

      // ---------------- flush and stall together: flush wins ----------------
      drive(1'b1, 32'h5000, 5'd10, 1'b1, 2'b00, 32'h00000066, 32'd0, 32'd0, 3'd0);
      step();
      chk("fs_load_valid", {63'd0, bus.o_wb_valid}, 64'd1);
      bus.i_stall = 1'b1;
      bus.i_flush = 1'b1;
      step();
      exp_cnt++;
      chk("fs_valid", {63'd0, bus.o_wb_valid}, 64'd0);
      chk("fs_wren",  {63'd0, bus.o_rd_wren}, 64'd0);
      chk("fs_cnt",   bus.o_instret, exp_cnt);
      bus.i_stall = 1'b0;
      bus.i_flush = 1'b0;

      // ---------------- reset while an uncounted entry is stalled ----------------
      drive(1'b1, 32'h6000, 5'd11, 1'b1, 2'b00, 32'h00000077, 32'd0, 32'd0, 3'd0);
      step();
      chk("rs_load_cnt", bus.o_instret, exp_cnt);
      bus.i_stall = 1'b1;
      rst = 1'b1;
      step();
      chk("rs_valid",   {63'd0, bus.o_wb_valid}, 64'd0);
      chk("rs_wren",    {63'd0, bus.o_rd_wren}, 64'd0);
      chk("rs_data",    {32'd0, bus.o_rd_data}, 64'd0);
      chk("rs_instret", bus.o_instret, 64'd0);
      rst = 1'b0;
      bus.i_stall = 1'b0;
      step();
      chk("rs_after_cnt", bus.o_instret, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
